// File: rtl/conv_pkg.sv
// Shared types and helpers for the multi-filter convolution layer.
// Latency: n/a (types and constant/combinational functions only).
// Backpressure: n/a.
package conv_pkg;

    typedef enum logic [2:0] {
        eIDLE,
        eLOAD,
        eCOMPUTE,
        eBIAS,
        eDONE
    } state_e;

    // Number of output positions; degenerate geometries return 1 so that
    // port widths stay legal long enough for the elaboration check to fire.
    function automatic int out_height(input int h, input int k, input int s);
        if (s < 1 || k > h) return 1;
        return (h - k) / s + 1;
    endfunction

    // Arithmetic right shift by frac (truncating), then clamp to a signed
    // range of the given width.
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                     input int frac,
                                                     input int width);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = acc >>> frac;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/ROM_neuron.sv
// Weight/bias ROM for one filter: taps at addresses 0..N_TAPS-1, bias at N_TAPS.
// Latency: 1 cycle registered read.
// Backpressure: none; address is read every cycle.
module ROM_neuron #(
    parameter int LAYER_NUMBER  = 1,
    parameter int NEURON_NUMBER = 0,
    parameter int N_TAPS        = 10,
    parameter int WORD_SIZE     = 16,
    parameter int FRAC          = 12,
    parameter int ADDR_W        = 4
) (
    input  logic                 clk_i,
    input  logic [ADDR_W-1:0]    addr_i,
    output logic [WORD_SIZE-1:0] data_o
);

    localparam int ONE = 1 << FRAC;

    // Weight sets per layer; odd neurons use negated weights where a set is signed.
    function automatic int rom_val(input int a);
        int sgn;
        sgn = (NEURON_NUMBER % 2 == 1) ? -1 : 1;
        if (a > N_TAPS) return 0;
        case (LAYER_NUMBER)
            1:       return (a < N_TAPS) ? ONE / 2 : 0;
            2:       return (a < N_TAPS) ? sgn * 7 * ONE : 0;
            4:       return (a == 0) ? ONE : 0;
            5:       return (a < N_TAPS) ? sgn * (a + 1) * (ONE / 16)
                                         : (2 + NEURON_NUMBER) * (ONE / 16);
            default: return 0;
        endcase
    endfunction

    // Registered ROM read.
    always_ff @(posedge clk_i) begin
        data_o <= WORD_SIZE'(rom_val(int'(addr_i)));
    end

endmodule

// File: rtl/conv_mac_unit.sv
// One output position of one filter: accumulate products and a shifted bias, present saturated result.
// Latency: accumulator updates on the clock edge; output stage is combinational from the accumulator.
// Backpressure: none; controller gates en/add_bias/clear.
module conv_mac_unit
    import conv_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int INT_BITS  = 4,
    parameter int ACC_W     = 36,
    parameter int RELU_EN   = 0
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic                 add_bias_i,
    input  logic [WORD_SIZE-1:0] w_i,
    input  logic [WORD_SIZE-1:0] x_i,
    output logic [WORD_SIZE-1:0] data_o
);

    localparam int FRAC = WORD_SIZE - INT_BITS;

    logic signed [ACC_W-1:0]       acc_q;
    logic signed [ACC_W-1:0]       acc_d;
    logic signed [2*WORD_SIZE-1:0] prod;
    logic        [WORD_SIZE-1:0]   sat;

    assign prod = $signed(w_i) * $signed(x_i);

    // Next accumulator value: clear wins, bias and tap products are never concurrent.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (add_bias_i) begin
            acc_d = acc_q + (ACC_W'($signed(w_i)) <<< FRAC);
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // Accumulator register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign sat    = WORD_SIZE'(sat_shift(64'(acc_q), FRAC, WORD_SIZE));
    assign data_o = (RELU_EN != 0 && sat[WORD_SIZE-1]) ? '0 : sat;

endmodule

// File: rtl/conv_layer_multi.sv
// Buffers one frame from a valid/ready stream and convolves it with NUM_FILTERS kernels in parallel.
// Latency: N_TAPS+2 cycles from the last accepted input word to valid_o.
// Backpressure: ready_o only in LOAD; results held on data_o until yumi_i.
module conv_layer_multi
    import conv_pkg::*;
#(
    parameter int INPUT_LAYER_HEIGHT = 64,
    parameter int KERNEL_HEIGHT      = 5,
    parameter int KERNEL_WIDTH       = 2,
    parameter int NUM_FILTERS        = 4,
    parameter int STRIDE             = 1,
    parameter int WORD_SIZE          = 16,
    parameter int INT_BITS           = 4,
    parameter int RELU_EN            = 0,
    parameter int LAYER_NUMBER       = 1,
    parameter int FILTER_BASE        = 0
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WORD_SIZE-1:0] data_i,
    output logic                 valid_o,
    input  logic                 yumi_i,
    output logic [NUM_FILTERS-1:0][out_height(INPUT_LAYER_HEIGHT, KERNEL_HEIGHT, STRIDE)-1:0][WORD_SIZE-1:0] data_o
);

    localparam int OUT_HEIGHT = out_height(INPUT_LAYER_HEIGHT, KERNEL_HEIGHT, STRIDE);
    localparam int N_TAPS     = KERNEL_HEIGHT * KERNEL_WIDTH;
    localparam int N_WORDS    = INPUT_LAYER_HEIGHT * KERNEL_WIDTH;
    localparam int FRAC       = WORD_SIZE - INT_BITS;
    localparam int TAP_W      = $clog2(N_TAPS + 1);
    localparam int LD_W       = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int ACC_W      = 2 * WORD_SIZE + $clog2(N_TAPS + 1);

    if (STRIDE < 1) begin : g_bad_stride
        $error("conv_layer_multi: STRIDE must be at least 1");
    end
    if (KERNEL_HEIGHT > INPUT_LAYER_HEIGHT) begin : g_bad_kernel
        $error("conv_layer_multi: KERNEL_HEIGHT exceeds INPUT_LAYER_HEIGHT");
    end

    state_e                state_q, state_d;
    logic [LD_W-1:0]       ld_cnt_q, ld_cnt_d;
    logic [TAP_W-1:0]      tap_q, tap_d;     // ROM address; N_TAPS selects the bias
    logic [TAP_W-1:0]      mac_tap_q;        // tap whose weight is on the ROM output
    logic                  mac_en_q;
    logic                  bias_ph_q;        // second BIAS cycle: bias word is on the ROM output
    logic                  mac_clr;
    logic                  add_bias;
    logic [WORD_SIZE-1:0]  frame_q [N_WORDS];
    logic [WORD_SIZE-1:0]  w_q [NUM_FILTERS];

    // Next-state and handshake outputs.
    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        tap_d    = tap_q;
        ready_o  = 1'b0;
        valid_o  = 1'b0;
        mac_clr  = 1'b0;
        add_bias = 1'b0;
        case (state_q)
            eIDLE: begin
                if (start_i) begin
                    state_d  = eLOAD;
                    ld_cnt_d = '0;
                end
            end
            eLOAD: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    if (ld_cnt_q == LD_W'(N_WORDS - 1)) begin
                        state_d  = eCOMPUTE;
                        ld_cnt_d = '0;
                        tap_d    = '0;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                    end
                end
            end
            eCOMPUTE: begin
                if (tap_q == TAP_W'(N_TAPS - 1)) begin
                    state_d = eBIAS;
                end
                tap_d = tap_q + 1'b1;
            end
            eBIAS: begin
                add_bias = bias_ph_q;
                if (bias_ph_q) begin
                    state_d = eDONE;
                    tap_d   = '0;
                end
            end
            eDONE: begin
                valid_o = 1'b1;
                if (yumi_i) begin
                    mac_clr = 1'b1;
                    state_d = eIDLE;
                end
            end
            default: state_d = eIDLE;
        endcase
    end

    // Control registers; the MAC enable and tap index trail the ROM address by one cycle.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= eIDLE;
            ld_cnt_q  <= '0;
            tap_q     <= '0;
            mac_tap_q <= '0;
            mac_en_q  <= 1'b0;
            bias_ph_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_cnt_q  <= ld_cnt_d;
            tap_q     <= tap_d;
            mac_tap_q <= tap_q;
            mac_en_q  <= (state_q == eCOMPUTE);
            bias_ph_q <= (state_q == eBIAS) && !bias_ph_q;
        end
    end

    // Frame buffer fill; contents are don't-care until a full frame has loaded.
    always_ff @(posedge clk_i) begin
        if (valid_i && ready_o) begin
            frame_q[ld_cnt_q] <= data_i;
        end
    end

    for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_filt
        ROM_neuron #(
            .LAYER_NUMBER (LAYER_NUMBER),
            .NEURON_NUMBER(FILTER_BASE + f),
            .N_TAPS       (N_TAPS),
            .WORD_SIZE    (WORD_SIZE),
            .FRAC         (FRAC),
            .ADDR_W       (TAP_W)
        ) u_rom (
            .clk_i (clk_i),
            .addr_i(tap_q),
            .data_o(w_q[f])
        );

        for (genvar p = 0; p < OUT_HEIGHT; p++) begin : g_pos
            // Row-major, channel-fastest layout: window p starts at word p*STRIDE*KERNEL_WIDTH.
            localparam logic [LD_W-1:0] X_BASE = LD_W'(p * STRIDE * KERNEL_WIDTH);

            conv_mac_unit #(
                .WORD_SIZE(WORD_SIZE),
                .INT_BITS (INT_BITS),
                .ACC_W    (ACC_W),
                .RELU_EN  (RELU_EN)
            ) u_mac (
                .clk_i     (clk_i),
                .reset_i   (reset_i),
                .clear_i   (mac_clr),
                .en_i      (mac_en_q),
                .add_bias_i(add_bias),
                .w_i       (w_q[f]),
                .x_i       (frame_q[X_BASE + LD_W'(mac_tap_q)]),
                .data_o    (data_o[f][p])
            );
        end
    end

endmodule

// File: tb/tb_conv_layer_multi.sv
// Bench for conv_layer_multi: five lockstep instances (H=8, K=3, 2 channels, 2 filters)
// share one input stream; each frame is checked against hand values and a behavioural model.
module tb_conv_layer_multi;

    localparam int NW     = 16;
    localparam int N_TAPS = 6;
    localparam int KW     = 2;
    localparam int LAY  [5] = '{1, 2, 2, 4, 5};
    localparam int STR  [5] = '{1, 1, 1, 2, 1};
    localparam int RELU [5] = '{0, 0, 1, 0, 0};

    typedef struct {
        int          pat;
        int          inst;
        int          f;
        int          p;
        logic [15:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        vld = 1'b0;
    logic        yumi = 1'b0;
    logic [15:0] dat = '0;

    logic rdy_a, rdy_s0, rdy_s1, rdy_st, rdy_m;
    logic vo_a, vo_s0, vo_s1, vo_st, vo_m;
    logic [1:0][5:0][15:0] do_a, do_s0, do_s1, do_m;
    logic [1:0][2:0][15:0] do_st;

    logic [15:0] frame [NW];
    vec_t        tbl [16];
    int          cur_pat;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    conv_layer_multi #(.INPUT_LAYER_HEIGHT(8), .KERNEL_HEIGHT(3), .KERNEL_WIDTH(2), .NUM_FILTERS(2),
        .STRIDE(1), .WORD_SIZE(16), .INT_BITS(4), .RELU_EN(0), .LAYER_NUMBER(1), .FILTER_BASE(0))
    u_a (.clk_i(clk), .reset_i(rst_n), .start_i(start), .valid_i(vld), .ready_o(rdy_a),
        .data_i(dat), .valid_o(vo_a), .yumi_i(yumi), .data_o(do_a));

    conv_layer_multi #(.INPUT_LAYER_HEIGHT(8), .KERNEL_HEIGHT(3), .KERNEL_WIDTH(2), .NUM_FILTERS(2),
        .STRIDE(1), .WORD_SIZE(16), .INT_BITS(4), .RELU_EN(0), .LAYER_NUMBER(2), .FILTER_BASE(0))
    u_s0 (.clk_i(clk), .reset_i(rst_n), .start_i(start), .valid_i(vld), .ready_o(rdy_s0),
        .data_i(dat), .valid_o(vo_s0), .yumi_i(yumi), .data_o(do_s0));

    conv_layer_multi #(.INPUT_LAYER_HEIGHT(8), .KERNEL_HEIGHT(3), .KERNEL_WIDTH(2), .NUM_FILTERS(2),
        .STRIDE(1), .WORD_SIZE(16), .INT_BITS(4), .RELU_EN(1), .LAYER_NUMBER(2), .FILTER_BASE(0))
    u_s1 (.clk_i(clk), .reset_i(rst_n), .start_i(start), .valid_i(vld), .ready_o(rdy_s1),
        .data_i(dat), .valid_o(vo_s1), .yumi_i(yumi), .data_o(do_s1));

    conv_layer_multi #(.INPUT_LAYER_HEIGHT(8), .KERNEL_HEIGHT(3), .KERNEL_WIDTH(2), .NUM_FILTERS(2),
        .STRIDE(2), .WORD_SIZE(16), .INT_BITS(4), .RELU_EN(0), .LAYER_NUMBER(4), .FILTER_BASE(0))
    u_st (.clk_i(clk), .reset_i(rst_n), .start_i(start), .valid_i(vld), .ready_o(rdy_st),
        .data_i(dat), .valid_o(vo_st), .yumi_i(yumi), .data_o(do_st));

    conv_layer_multi #(.INPUT_LAYER_HEIGHT(8), .KERNEL_HEIGHT(3), .KERNEL_WIDTH(2), .NUM_FILTERS(2),
        .STRIDE(1), .WORD_SIZE(16), .INT_BITS(4), .RELU_EN(0), .LAYER_NUMBER(5), .FILTER_BASE(0))
    u_m (.clk_i(clk), .reset_i(rst_n), .start_i(start), .valid_i(vld), .ready_o(rdy_m),
        .data_i(dat), .valid_o(vo_m), .yumi_i(yumi), .data_o(do_m));

    task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Weight sets as documented for the ROM (Q4.12); index N_TAPS is the bias.
    function automatic int tb_w(input int layer, input int n, input int t);
        int sg;
        sg = (n % 2 == 1) ? -1 : 1;
        case (layer)
            1:       return (t < N_TAPS) ? 2048 : 0;
            2:       return (t < N_TAPS) ? sg * 28672 : 0;
            4:       return (t == 0) ? 4096 : 0;
            default: return (t < N_TAPS) ? sg * (t + 1) * 256 : (2 + n) * 256;
        endcase
    endfunction

    function automatic logic [15:0] model(input int inst, input int f, input int p);
        longint      acc;
        longint      s;
        logic [63:0] sv;
        acc = 0;
        for (int t = 0; t < N_TAPS; t++)
            acc += longint'(tb_w(LAY[inst], f, t)) * longint'($signed(frame[p * STR[inst] * KW + t]));
        acc += longint'(tb_w(LAY[inst], f, N_TAPS)) * 4096;
        s = acc >>> 12;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (RELU[inst] != 0 && s < 0) s = 0;
        sv = s;
        return sv[15:0];
    endfunction

    function automatic logic [15:0] get_out(input int inst, input int f, input int p);
        case (inst)
            0:       return do_a[f][p];
            1:       return do_s0[f][p];
            2:       return do_s1[f][p];
            3:       return do_st[f][p];
            default: return do_m[f][p];
        endcase
    endfunction

    task automatic set_frame(input int pat);
        cur_pat = pat;
        for (int i = 0; i < NW; i++) begin
            case (pat)
                0:       frame[i] = 16'h1000;
                1:       frame[i] = 16'h7000;
                2:       frame[i] = 16'(i / 2) * 16'h1000;
                default: frame[i] = 16'($urandom_range(0, 16383)) - 16'd8192;
            endcase
        end
    endtask

    task automatic load_frame(input int nw, input int gaps);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < nw; i++) begin
            if (gaps != 0) begin
                vld = 1'b0;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            vld = 1'b1;
            dat = frame[i];
            for (int b = 0; b < 20 && !rdy_m; b++) begin @(posedge clk); #1; end
            check($sformatf("ready_load_w%0d", i), 192'(rdy_m), 192'(1));
            @(posedge clk); #1;
        end
        vld = 1'b0;
    endtask

    task automatic check_model(input string nm, input int inst);
        int oh;
        oh = (STR[inst] == 2) ? 3 : 6;
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < oh; p++)
                check($sformatf("%s_i%0d_f%0d_p%0d", nm, inst, f, p),
                      192'(get_out(inst, f, p)), 192'(model(inst, f, p)));
    endtask

    task automatic finish_frame(input int hold);
        int cyc;
        cyc = 0;
        while (!vo_m && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check("latency", 192'(cyc), 192'(N_TAPS + 2));
        check("valid_all", 192'({vo_a, vo_s0, vo_s1, vo_st, vo_m}), 192'(5'b11111));
        for (int k = 0; k < 5; k++) check_model("model", k);
        for (int i = 0; i < 16; i++)
            if (tbl[i].pat == cur_pat)
                check($sformatf("tbl%0d", i), 192'(get_out(tbl[i].inst, tbl[i].f, tbl[i].p)),
                      192'(tbl[i].exp));
        for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            vld   = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", 192'(vo_m), 192'(1));
            check("hold_ready", 192'(rdy_m), 192'(0));
            check_model("hold", 4);
        end
        yumi  = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        yumi  = 1'b0;
        start = 1'b0;
        vld   = 1'b0;
        check("valid_fall", 192'(vo_m), 192'(0));
        check("ready_after_yumi", 192'(rdy_m), 192'(0));
        check("clear_m", 192'(do_m), 192'(0));
    endtask

    task automatic reset_pulse(input string nm);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check({nm, "_valid"}, 192'(vo_m), 192'(0));
        check({nm, "_ready"}, 192'(rdy_m), 192'(0));
        check({nm, "_do_m"}, 192'(do_m), 192'(0));
        check({nm, "_do_a"}, 192'(do_a), 192'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check({nm, "_idle"}, 192'(rdy_m), 192'(0));
    endtask

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 16'h3000};
        tbl[1]  = '{0, 0, 1, 5, 16'h3000};
        tbl[2]  = '{0, 0, 0, 3, 16'h3000};
        tbl[3]  = '{0, 3, 1, 1, 16'h1000};
        tbl[4]  = '{1, 1, 0, 0, 16'h7FFF};
        tbl[5]  = '{1, 1, 1, 2, 16'h8000};
        tbl[6]  = '{1, 2, 0, 4, 16'h7FFF};
        tbl[7]  = '{1, 2, 1, 1, 16'h0000};
        tbl[8]  = '{1, 0, 1, 0, 16'h7FFF};
        tbl[9]  = '{2, 3, 0, 0, 16'h0000};
        tbl[10] = '{2, 3, 0, 1, 16'h2000};
        tbl[11] = '{2, 3, 1, 2, 16'h4000};
        tbl[12] = '{2, 3, 1, 0, 16'h0000};
        tbl[13] = '{2, 0, 0, 2, 16'h7FFF};
        tbl[14] = '{2, 0, 1, 1, 16'h6000};
        tbl[15] = '{2, 0, 0, 0, 16'h3000};
        cur_pat = -1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 192'(vo_m), 192'(0));
        check("rst_ready", 192'(rdy_m), 192'(0));
        check("rst_do_m", 192'(do_m), 192'(0));
        check("rst_do_st", 192'(do_st), 192'(0));
        rst_n = 1'b1;

        yumi = 1'b1;
        @(posedge clk); #1;
        yumi = 1'b0;
        check("yumi_idle_valid", 192'(vo_m), 192'(0));
        check("yumi_idle_ready", 192'(rdy_m), 192'(0));

        for (int pat = 0; pat < 3; pat++) begin
            set_frame(pat);
            load_frame(NW, 0);
            finish_frame(2);
        end

        set_frame(3);
        load_frame(NW, 1);
        finish_frame(10);
        set_frame(3);
        load_frame(NW, 1);
        finish_frame(1);

        set_frame(3);
        load_frame(7, 0);
        reset_pulse("rst_load");
        set_frame(3);
        load_frame(NW, 0);
        finish_frame(1);

        set_frame(3);
        load_frame(NW, 0);
        repeat (3) begin @(posedge clk); #1; end
        reset_pulse("rst_comp");
        set_frame(3);
        load_frame(NW, 1);
        finish_frame(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
